// File: rtl/npc_rsp_if.sv
// np-core request bus between one initiator and the scratchpad responder.
// master drives req/rwn/adr/len/wdt; slave returns gnt/ack/rdt.
interface npc_rsp_if;
    logic        npc_req;
    logic        npc_gnt;
    logic        npc_rwn;
    logic [31:0] npc_adr;
    logic [31:0] npc_len;
    logic [31:0] npc_wdt;
    logic [31:0] npc_rdt;
    logic        npc_ack;

    modport master (
        output npc_req, npc_rwn, npc_adr, npc_len, npc_wdt,
        input  npc_gnt, npc_rdt, npc_ack
    );

    modport slave (
        input  npc_req, npc_rwn, npc_adr, npc_len, npc_wdt,
        output npc_gnt, npc_rdt, npc_ack
    );
endinterface

// File: rtl/npc_rsp.sv
// Scratchpad responder: bursts words into/out of a 2^AW x 32 RAM.
// Ports: clk, rst (async high), bus (npc_rsp_if.slave), busy.
module npc_rsp #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic clk,
    input  logic rst,
    npc_rsp_if.slave bus,
    output logic busy
);
    localparam logic [3:0] W = 4'(WAIT);

    typedef enum logic [2:0] {
        IDLE, GNT, WR, RD, RDW
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [31:0]   rem;
    logic [3:0]    cnt;
    logic          gnt_q;
    logic          ack_q;
    logic          iss_q;
    logic [31:0]   rdt_q;
    logic          busy_q;
    logic          we;

    logic [31:0] mem [2**AW];

    logic unused_adr;
    assign unused_adr = ^{bus.npc_adr[31:AW+2], bus.npc_adr[1:0]};

    assign bus.npc_gnt = gnt_q;
    assign bus.npc_ack = ack_q;
    assign bus.npc_rdt = rdt_q;
    assign busy        = busy_q;

    // ack clears asynchronously, so a reset never lands a stray write
    assign we = (state == WR) && ack_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr] <= bus.npc_wdt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            rem    <= '0;
            cnt    <= '0;
            gnt_q  <= 1'b0;
            ack_q  <= 1'b0;
            iss_q  <= 1'b0;
            rdt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.npc_req) begin
                        state  <= GNT;
                        gnt_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                GNT: begin
                    gnt_q <= 1'b0;
                    ptr   <= bus.npc_adr[AW+1:2];
                    rem   <= bus.npc_len;
                    if (bus.npc_len == 32'd0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state <= bus.npc_rwn ? RD : WR;
                        if (W == 4'd0) begin
                            ack_q <= ~bus.npc_rwn;
                            iss_q <= bus.npc_rwn;
                        end else begin
                            cnt <= W;
                        end
                    end
                end
                WR: begin
                    if (ack_q) begin
                        ptr <= ptr + AW'(1);
                        rem <= rem - 32'd1;
                        if (rem == 32'd1) begin
                            ack_q  <= 1'b0;
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else if (W != 4'd0) begin
                            ack_q <= 1'b0;
                            cnt   <= W;
                        end
                    end else if (cnt == 4'd1) begin
                        ack_q <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD: begin
                    // iss marks the RAM read; its data acks next cycle
                    ack_q <= iss_q;
                    if (iss_q) begin
                        rdt_q <= mem[ptr];
                        ptr   <= ptr + AW'(1);
                        rem   <= rem - 32'd1;
                        if (rem == 32'd1) begin
                            iss_q <= 1'b0;
                            state <= RDW;
                        end else if (W != 4'd0) begin
                            iss_q <= 1'b0;
                            cnt   <= W;
                        end
                    end else if (cnt == 4'd1) begin
                        iss_q <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RDW: begin
                    ack_q  <= 1'b0;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/npc_rsp.md
# npc_rsp

Local scratchpad responder for the np-core request interface (req/gnt/rwn/adr/len/wdt/rdt/ack). It is the target end of the protocol that each npc drives. It lets one core burst words into or out of an on-chip RAM without going through the AXI master path. The block is instantiated per core beside the master arbiter port, and every signal is in the core clock domain.

## Interface

Parameters:
- AW, 10: RAM word-address width. Depth is 2^AW 32-bit words.
- WAIT, 0: idle cycles inserted before every data beat (0..15).

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- npc_req  in  1  transfer request; held until npc_gnt is seen.
- npc_gnt  out  1  one-cycle grant pulse.
- npc_rwn  in  1  1 = read, 0 = write. Valid while npc_req is high.
- npc_adr  in  32  byte address. Word index = adr[AW+1:2]; adr[1:0] and adr[31:AW+2] are ignored.
- npc_len  in  32  burst length in 32-bit words.
- npc_wdt  in  32  write data for the current beat.
- npc_rdt  out  32  read data; valid only while npc_ack=1.
- npc_ack  out  1  beat strobe, one per word.
- busy  out  1  high in any state other than IDLE.

## Operation

States: IDLE, GNT, WR, RD, and a ready-wait stage after RD entry (RDW).
- **IDLE:** if npc_req=1 → GNT. npc_req is ignored in every other state.
- **GNT:** npc_gnt=1 for exactly this cycle. At the end edge, capture rwn, ptr=adr[AW+1:2], and rem=len.
  - len==0 → IDLE, with no ack.
  - rwn=0 → WR.
  - rwn=1 → RD.
- **WR:** wait counter runs WAIT cycles, then npc_ack=1 for one cycle. On that edge: mem[ptr]<=npc_wdt, ptr<=ptr+1 (mod 2^AW), rem<=rem-1. When rem reaches 0 → IDLE.
- **RD:** the RAM read of mem[ptr] is issued WAIT cycles after entry. One cycle later npc_ack=1 with npc_rdt=mem[ptr].
  - Reads are pipelined, so beats are back-to-back when WAIT=0.
  - ptr and rem advance per beat as in WR.
  - After the final ack → IDLE.
- **Address wrap:** ptr wraps modulo 2^AW. No error is raised.
- **rem:** a 32-bit down-counter. len up to 2^32-1 is legal.
- **Initiator obligations:**
  - Drop npc_req in the cycle after npc_gnt.
  - Hold rwn, adr and len stable from req until gnt.
  - Advance npc_wdt on the edge where npc_ack=1 is sampled.
- **Reset:**
  - Any state → IDLE immediately.
  - npc_gnt=0, npc_ack=0, npc_rdt=0, busy=0.
  - ptr, rem and the wait counter clear.
  - RAM contents are not reset and are retained.
  - A transfer cut by reset is abandoned. Words already acked are written; the rest are not.

## Timing

Cycle 0 is the cycle in which npc_req=1 is sampled in IDLE.
- Grant: npc_gnt=1 in cycle 1. busy=1 from cycle 1 until the cycle after the last ack.
- Write: beat k (k=0..len-1) acks in cycle 2+W+k(W+1).
- Read: beat k acks in cycle 3+W+k(W+1).
- Return to IDLE: busy=0 in the cycle after the last ack. The earliest next grant is 2 cycles after the last ack. For len=0, busy=0 in cycle 2.
- Outputs: npc_gnt, npc_ack, npc_rdt and busy are all registered, with no combinational path from inputs.
- npc_rdt holds its last value when npc_ack=0. It must not be sampled then.

## Test plan

- **Reset:** assert rst for 3 cycles mid-idle → npc_gnt, npc_ack and busy are 0, and npc_rdt=0 while rst is high and on the first cycle after release.
- **Write burst:** WAIT=0, write adr=0x10, len=4, wdt 0xA0..0xA3 → gnt in cycle 1, acks in cycles 2..5, busy=0 in cycle 6, and mem[4..7]=A0..A3.
- **Read burst:** read back adr=0x10, len=4 → acks in cycles 3..6 with rdt=0xA0,0xA1,0xA2,0xA3 on those cycles.
- **Wrap:** AW=10, write adr=0xFFC, len=2, data 0x11,0x22 → mem[1023]=0x11 and mem[0]=0x22. A read of adr=0x0, len=1 returns 0x22.
- **Zero length and throttling:**
  - len=0 request → one gnt pulse, no ack, busy=0 in cycle 2, and a second req is granted in cycle 3.
  - WAIT=2 read, len=3 → acks in cycles 5, 8, 11.
- **Reset mid-burst:** write len=8 with rst asserted after the 3rd ack → IDLE at once with all outputs 0. A subsequent read shows words 0..2 written and words 3..7 unchanged.
